// File: rtl/sigmoid_arbiter.sv
// sigmoid_arbiter
//   Shares one combinational sigmoid LUT between N_REQ requesters.
//   Round-robin grant, one lookup accepted per cycle, two registered
//   stages, and a response tagged one-hot to the requester that issued it.
//
// Parameters
//   N_REQ   number of requesters (2..16)
//   DATA_W  LUT operand/result width
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   en         1 = grants allowed; 0 = no new grants, in-flight lookups drain
//   req_valid  per-requester lookup request
//   req_data   requester i operand at [i*DATA_W +: DATA_W]
//   req_ready  one-hot grant (combinational)
//   lut_in     registered operand driven to the LUT
//   lut_out    combinational LUT result for lut_in
//   rsp_valid  one-hot, single-cycle response tag
//   rsp_data   registered LUT result
//   busy       a lookup is in stage 1 or stage 2
//   grant_cnt  per-requester 16-bit transfer counters (only with the macro)
//
// Build option
//   SIGMOID_ARB_STATS_EN  adds the grant_cnt port and its counters.

module sigmoid_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ready,
  output logic [DATA_W-1:0]         lut_in,
  input  logic [DATA_W-1:0]         lut_out,
  output logic [N_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      busy
`ifdef SIGMOID_ARB_STATS_EN
  ,
  output logic [N_REQ*16-1:0]       grant_cnt
`endif
);

  localparam int ID_W = $clog2(N_REQ);

  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   gidx;
  logic [ID_W-1:0]   cand;
  logic              found;
  logic              xfer;
  logic [DATA_W-1:0] sel_data;
  logic [ID_W-1:0]   id1;
  logic              v1;
  int unsigned       idx;

  // Search from ptr upward with wrap at N_REQ; first valid wins.
  always_comb begin
    req_ready = '0;
    gidx      = '0;
    cand      = '0;
    found     = 1'b0;
    idx       = 0;
    if (en && !rst) begin
      for (int unsigned k = 0; k < N_REQ; k++) begin
        idx = 32'(ptr) + k;
        if (idx >= 32'(N_REQ)) idx = idx - 32'(N_REQ);
        cand = ID_W'(idx);
        if (!found && req_valid[cand]) begin
          found           = 1'b1;
          req_ready[cand] = 1'b1;
          gidx            = cand;
        end
      end
    end
  end

  assign xfer = |req_ready;

  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (req_ready[i]) sel_data = req_data[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      lut_in    <= '0;
      id1       <= '0;
      v1        <= 1'b0;
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      // Stage 1
      v1 <= xfer;
      if (xfer) begin
        lut_in <= sel_data;
        id1    <= gidx;
        ptr    <= (gidx == ID_W'(N_REQ - 1)) ? '0 : gidx + ID_W'(1);
      end
      // Stage 2
      if (v1) begin
        rsp_data  <= lut_out;
        rsp_valid <= N_REQ'(1) << id1;
      end else begin
        rsp_valid <= '0;
      end
    end
  end

  assign busy = v1 | (|rsp_valid);

`ifdef SIGMOID_ARB_STATS_EN
  logic [15:0] cnt [N_REQ];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_REQ; i++) cnt[i] <= '0;
    end else if (xfer) begin
      cnt[gidx] <= cnt[gidx] + 16'd1;
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int unsigned i = 0; i < N_REQ; i++) grant_cnt[i*16 +: 16] = cnt[i];
  end
`endif

endmodule

// File: tb/tb_sigmoid_arbiter.sv
// tb_sigmoid_arbiter
//   Bench for sigmoid_arbiter (N_REQ=4, DATA_W=8). Supplies a sigmoid LUT
//   (floor(100 * sigmoid(x/10)) on the signed operand) and keeps a
//   transaction-level reference: round-robin pointer plus a queue of
//   pending responses with the edge at which each one must appear.
//   Build with SIGMOID_ARB_STATS_EN to also cover grant_cnt.

module tb_sigmoid_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b1;
  logic [N-1:0]  req_valid = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]  req_ready;
  logic [DW-1:0] lut_in;
  logic [DW-1:0] lut_out;
  logic [N-1:0]  rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          busy;
`ifdef SIGMOID_ARB_STATS_EN
  logic [N*16-1:0] grant_cnt;
`endif

  always #5 clk = ~clk;

  sigmoid_arbiter #(.N_REQ(N), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .lut_in    (lut_in),
    .lut_out   (lut_out),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy)
`ifdef SIGMOID_ARB_STATS_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  function automatic logic [7:0] sig(input logic [7:0] x);
    real r;
    r = $itor($signed(x)) / 10.0;
    return 8'(int'($floor(100.0 / (1.0 + $exp(-r)))));
  endfunction

  always_comb lut_out = sig(lut_in);

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int unsigned due;
    int          id;
    logic [7:0]  data;
  } rsp_t;

  rsp_t        q[$];
  int          m_ptr = 0;
  logic [7:0]  m_lut_in = '0;
  logic [7:0]  m_rsp_data = '0;
  int unsigned ec = 1;
  int          m_cnt[N];

  function automatic int model_grant(input logic [N-1:0] v, input logic e,
                                     input logic r, input int p);
    if (!e || r) return -1;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (p + k) % N;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  // Compare after each edge, then advance the model with the inputs that the
  // next edge will sample (inputs only change just after a rising edge).
  initial begin
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    forever begin
      int g;
      logic [N-1:0] exp_rv;
      logic [7:0]   d;
      @(negedge clk);
      g = model_grant(req_valid, en, rst, m_ptr);
      check("req_ready", 64'(req_ready), (g >= 0) ? 64'(1 << g) : 64'd0);
      check("lut_in", 64'(lut_in), 64'(m_lut_in));
      exp_rv = (q.size() > 0 && q[0].due == ec) ? N'(1 << q[0].id) : '0;
      check("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
      check("rsp_data", 64'(rsp_data), 64'(m_rsp_data));
      check("busy", 64'(busy), 64'(q.size() != 0));
`ifdef SIGMOID_ARB_STATS_EN
      begin
        logic [N*16-1:0] ec_cnt;
        for (int i = 0; i < N; i++) ec_cnt[i*16 +: 16] = 16'(m_cnt[i]);
        check("grant_cnt", 64'(grant_cnt), 64'(ec_cnt));
      end
`endif
      ec++;
      if (rst) begin
        q.delete();
        m_ptr      = 0;
        m_lut_in   = '0;
        m_rsp_data = '0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
      end else begin
        if (g >= 0) begin
          d        = req_data[g*DW +: DW];
          m_lut_in = d;
          q.push_back('{due: ec + 1, id: g, data: sig(d)});
          m_ptr    = (g + 1) % N;
          m_cnt[g] = (m_cnt[g] + 1) % 65536;
        end
        while (q.size() > 0 && q[0].due < ec) void'(q.pop_front());
        if (q.size() > 0 && q[0].due == ec) m_rsp_data = q[0].data;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] exp_tab [4];

  initial begin
    exp_tab[0] = 8'd50; exp_tab[1] = 8'd88; exp_tab[2] = 8'd26; exp_tab[3] = 8'd99;
    repeat (2) step();
    rst = 1'b0;

    // Reset with a lookup in flight: it must vanish without a response.
    req_valid = 4'b0001;
    req_data  = {24'h0, 8'h0A};
    step();
    check("t1_lut_in", 64'(lut_in), 64'h0A);
    req_valid = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("t1_rsp_valid", 64'(rsp_valid), 64'd0);
    check("t1_lut_in_rst", 64'(lut_in), 64'd0);
    check("t1_busy", 64'(busy), 64'd0);

    // Single lookup.
    step();
    req_valid = 4'b0001;
    req_data  = {24'h0, 8'h0A};
    @(negedge clk);
    check("t2_ready", 64'(req_ready), 64'b0001);
    step();
    req_valid = '0;
    step();
    check("t2_rsp_valid", 64'(rsp_valid), 64'b0001);
    check("t2_rsp_data", 64'(rsp_data), 64'd73);

    // Fair arbitration from ptr=0.
    rst = 1'b1;
    step();
    rst = 1'b0;
    req_data  = {8'h7F, 8'hF6, 8'h14, 8'h00};
    req_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("t3_grant", 64'(req_ready), 64'(1 << (k % 4)));
      if (k >= 2) begin
        check("t3_rsp_valid", 64'(rsp_valid), 64'(1 << ((k - 2) % 4)));
        check("t3_rsp_data", 64'(rsp_data), 64'(exp_tab[(k - 2) % 4]));
      end
    end

    // Pointer wrap after a grant to 3.
    step();
    req_valid = 4'b1010;
    @(negedge clk);
    check("t4_first", 64'(req_ready), 64'b0010);
    step();
    @(negedge clk);
    check("t4_second", 64'(req_ready), 64'b1000);

    // Enable drain.
    step();
    req_valid = 4'b0011;
    step();
    step();
    en = 1'b0;
    @(negedge clk);
    check("t5_ready_off", 64'(req_ready), 64'd0);
    step();
    check("t5_rsp2", 64'(|rsp_valid), 64'd1);
    check("t5_busy_hi", 64'(busy), 64'd1);
    step();
    check("t5_busy_lo", 64'(busy), 64'd0);
    check("t5_ready_hold", 64'(req_ready), 64'd0);
    en = 1'b1;
    req_valid = '0;

    // Randomised traffic.
    for (int c = 0; c < 400; c++) begin
      step();
      req_valid = N'($urandom);
      req_data  = $urandom;
      en        = ($urandom % 8) != 0;
      rst       = ($urandom % 40) == 0;
    end
    step();
    rst = 1'b0;
    en = 1'b1;
    req_valid = '0;
    repeat (3) step();

`ifdef SIGMOID_ARB_STATS_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    req_valid = 4'b0100;
    repeat (70000) step();
    req_valid = '0;
    step();
    check("t6_grant_cnt", 64'(grant_cnt), {16'd0, 16'd4464, 16'd0, 16'd0});
`endif

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
